// File: rtl/sv_timer_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sv_timer_irq                                                     |
// | Purpose  : Prescaled one-shot down-counter timers with status/ack/enable    |
// |            IRQ logic and an external (DMA) IRQ source on the CPU reg bus.   |
// | Options  : define SV_TIMER_AUTORELOAD_EN for periodic (auto-reload) timers. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sv_timer_irq #(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 8,
  parameter int PRESC_LO   = 256,
  parameter int PRESC_HI   = 16384
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_cpu,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       ext_irq,
  output logic       irq
);

  localparam logic [7:0]  c_TMR_MASK    = 8'((1 << NUM_TIMERS) - 1);
  localparam logic [7:0]  c_STAT_MASK   = 8'h80 | c_TMR_MASK;
`ifdef SV_TIMER_AUTORELOAD_EN
  localparam logic [7:0]  c_CTRL_MASK   = 8'hB0 | c_TMR_MASK;
`else
  localparam logic [7:0]  c_CTRL_MASK   = 8'h90 | c_TMR_MASK;
`endif
  localparam logic [13:0] c_PRESC_LO_M1 = 14'(PRESC_LO - 1);
  localparam logic [13:0] c_PRESC_HI_M1 = 14'(PRESC_HI - 1);

  logic [13:0]           r_presc;
  logic [7:0]            r_status;
  logic [7:0]            r_ctrl;
  logic [7:0]            r_dout;
  logic                  r_irq;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic [NUM_TIMERS-1:0] w_expire;
  logic [7:0]            w_cnt_rd [NUM_TIMERS];
  logic [7:0]            w_set;
  logic [7:0]            w_clr;
  logic [7:0]            w_rdata;

  assign w_wr   = cs & we;
  assign w_rd   = cs & ~we;
  assign w_tick = ce_cpu & (r_presc == 14'd0);

  // Reload value is sampled at reload time, so a ctrl[4] change waits for it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (ce_cpu) begin
      if (r_presc == 14'd0) r_presc <= r_ctrl[4] ? c_PRESC_HI_M1 : c_PRESC_LO_M1;
      else                  r_presc <= r_presc - 14'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      logic             w_load;
      logic [CNT_W-1:0] w_zero_val;
      logic [CNT_W-1:0] r_cnt;

      assign w_load = w_wr && (addr == 3'(gi));

`ifdef SV_TIMER_AUTORELOAD_EN
      logic [CNT_W-1:0] r_reload;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)    r_reload <= '0;
        else if (w_load) r_reload <= din[CNT_W-1:0];
      end

      assign w_zero_val = r_ctrl[5] ? r_reload : '0;
`else
      assign w_zero_val = '0;
`endif

      // A bus write takes priority over a coincident tick.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (w_load) begin
          r_cnt <= din[CNT_W-1:0];
        end else if (w_tick && (r_cnt != '0)) begin
          if (r_cnt == CNT_W'(1)) r_cnt <= w_zero_val;
          else                    r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign w_expire[gi] = w_load ? (din[CNT_W-1:0] == '0)
                                   : (w_tick && (r_cnt == CNT_W'(1)));
      assign w_cnt_rd[gi] = 8'(r_cnt);
    end
  endgenerate

  always_comb begin
    w_set                  = '0;
    w_set[NUM_TIMERS-1:0]  = w_expire;
    w_set[7]               = ext_irq;
    w_clr                  = '0;
    if (w_wr && (addr == 3'd5)) w_clr = din;
    if (w_rd && (addr == 3'd7)) w_clr = 8'hFF;
  end

  // Set is OR-ed after clear so a coincident event is never lost.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_status <= '0;
    else          r_status <= ((r_status & ~w_clr) | w_set) & c_STAT_MASK;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                      r_ctrl <= '0;
    else if (w_wr && (addr == 3'd6))   r_ctrl <= din & c_CTRL_MASK;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= |(r_status & r_ctrl & c_STAT_MASK);
  end

  always_comb begin
    w_rdata = '0;
    case (addr)
      3'd4, 3'd7: w_rdata = r_status;
      3'd6:       w_rdata = r_ctrl;
      default: begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (addr == 3'(i)) w_rdata = w_cnt_rd[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  r_dout <= '0;
    else if (w_rd) r_dout <= w_rdata;
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule
`default_nettype wire
